williams_nvram_arb: RTL and testbench
=====================================

# williams_nvram_arb

Single-port arbiter for the Williams CMOS battery-backed RAM (high scores, audits, settings). It shares one synchronous RAM port between the CPU bus and the HPS ioctl channel. This lets the HPS load NVRAM contents at boot and save them on request while the game runs. It sits between `williams_soc` (CMOS chip-select region) and `hps_io`. The CPU always wins the port; HPS accesses are queued and throttled with `ioctl_wait`.

## Interface
Parameters:
- `AW`, 10 — NVRAM address width (1 K locations).
- `IDX`, 8'd4 — `ioctl_index` value that selects the NVRAM channel.

Ports (clock domain `clk_sys`; one clock; reset is synchronous and active-high):
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_cs`  in  1  CPU access to the CMOS region this cycle.
- `cpu_we`  in  1  CPU write when `cpu_cs`=1.
- `cpu_addr`  in  AW  CPU address.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  CPU read data, registered.
- `ioctl_download`  in  1  HPS→core transfer active.
- `ioctl_upload`  in  1  core→HPS transfer active.
- `ioctl_index`  in  8  transfer index.
- `ioctl_addr`  in  25  byte address.
- `ioctl_wr`  in  1  1-cycle write strobe.
- `ioctl_rd`  in  1  1-cycle read strobe.
- `ioctl_dout`  in  8  download data.
- `ioctl_din`  out  8  upload data, registered.
- `ioctl_wait`  out  1  HPS must hold off the next strobe.
- `ram_addr`  out  AW  RAM address (combinational mux).
- `ram_di`  out  8  RAM write data (combinational mux).
- `ram_we`  out  1  RAM write enable (combinational).
- `ram_q`  in  8  RAM read data, 1-cycle latency.
- `dirty`  out  1  CPU has written since the last completed upload.

## Operation
- `sel` = (`ioctl_index`==`IDX`). Strobes are ignored when `sel`=0 or when the matching `ioctl_download`/`ioctl_upload` is low.
- **Port owner:** the CPU whenever `cpu_cs`=1, otherwise the FSM.
  - CPU owner: `ram_addr`=`cpu_addr`, `ram_di`=`cpu_din`, `ram_we`=`cpu_we`.
- **FSM states:**
  - IDLE → WPEND on an accepted `ioctl_wr`; latch the address and data.
  - IDLE → RPEND on an accepted `ioctl_rd`; latch the address.
  - WPEND: on the first cycle with `cpu_cs`=0, drive `ram_we`=1 with the latched address/data, then go to IDLE.
  - RPEND: on the first cycle with `cpu_cs`=0, drive the latched address with `ram_we`=0, then go to RCAP.
  - RCAP: `ioctl_din`<=`ram_q`, then go to IDLE.
- **Out-of-range addresses** (`ioctl_addr`[24:AW]≠0): the FSM still passes through WPEND/RPEND, but the write is suppressed (`ram_we`=0). A read returns `ioctl_din`=8'hFF.
- **Strobe while not IDLE:** protocol violation; the strobe is dropped and the state is unchanged.
- **CPU reads:** `cpu_dout`<=`ram_q` in the cycle after any cycle with `cpu_cs`=1 and `cpu_we`=0. `cpu_dout` holds its value otherwise.
- **`dirty`:**
  - Set by any cycle with `cpu_cs` & `cpu_we`.
  - Cleared on the falling edge of `ioctl_upload` while `sel`=1.
  - If a set and a clear occur in the same cycle, set wins.
- **Reset:** FSM→IDLE, latches cleared, `ioctl_wait`=0, `ioctl_din`=0, `cpu_dout`=0, `dirty`=0. An in-flight HPS access is discarded, and no RAM write is issued in the reset cycle.

## Timing
- `ioctl_wait` is registered. It is 1 from the cycle after the accepting strobe until the cycle after the RAM write (write path) or after RCAP (read path).
  - HPS write with the port free: strobe at N, RAM write at N+1, `ioctl_wait` high at N+1, low at N+2.
  - HPS read with the port free: strobe at N, address at N+1, `ioctl_din` valid at N+3, `ioctl_wait` low at N+3.
- Each cycle with `cpu_cs`=1 during WPEND/RPEND delays the grant by one cycle. There is no timeout; the CPU bus guarantees idle cycles.
- CPU read: `cpu_cs` at N, `cpu_dout` valid at N+2. A CPU access in RCAP does not disturb the capture.
- CPU write: lands in the same cycle (`ram_we` combinational).

## Test plan
- **Reset:** assert `reset` mid-RPEND → next cycle all outputs 0 and FSM IDLE; a following `ioctl_rd` is accepted normally.
- **Download:** `sel`=1, `ioctl_wr` at `addr`=3, `dout`=8'h5A, `cpu_cs`=0 → `ram_we`=1 with `ram_addr`=3 and `ram_di`=8'h5A at N+1; `ioctl_wait` high for exactly 1 cycle.
- **Contention:** `ioctl_wr` at N with `cpu_cs`=1 for N+1..N+4 → CPU writes land unmodified; the HPS write lands at N+5; `ioctl_wait` is low at N+6.
- **Upload:** preload `addr`=7 with 8'hC3, `ioctl_rd` → `ioctl_din`=8'hC3 at N+3; `addr`=1024 → `ioctl_din`=8'hFF and no `ram_we`.
- **Dirty:** CPU write → `dirty`=1; complete an upload (`ioctl_upload` falls) → `dirty`=0; a CPU write in the same cycle as the fall leaves `dirty`=1.
- **Index filter:** `ioctl_wr` with `ioctl_index`=0 → no `ram_we`, `ioctl_wait` stays 0.

Source files
------------

// File: rtl/williams_nvram_arb.sv
// ---------------------------------------------------------------------------
// williams_nvram_arb
//
// Shares one synchronous single-port RAM (the Williams CMOS NVRAM) between the
// CPU bus and the HPS ioctl channel. The CPU always owns the port when it
// selects the CMOS region. HPS strobes are latched and then serviced on the
// first CPU-free cycle. While an HPS access is pending, ioctl_wait throttles
// the HPS.
//
// Ports:
//   i_clk_sys, i_reset          system clock, synchronous active-high reset
//   i_cpu_cs/we/addr/din        CPU access to the CMOS region
//   o_cpu_dout                  CPU read data, valid two cycles after cs
//   i_ioctl_*                   HPS ioctl channel inputs (index filtered by IDX)
//   o_ioctl_din                 upload data, registered
//   o_ioctl_wait                HPS must hold off its next strobe
//   o_ram_addr/di/we, i_ram_q   RAM port, read latency of one cycle
//   o_dirty                     CPU has written since the last completed upload
// ---------------------------------------------------------------------------
module williams_nvram_arb #(
    parameter int         AW  = 10,
    parameter logic [7:0] IDX = 8'd4
) (
    input  logic          i_clk_sys,
    input  logic          i_reset,
    input  logic          i_cpu_cs,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [7:0]    i_cpu_din,
    output logic [7:0]    o_cpu_dout,
    input  logic          i_ioctl_download,
    input  logic          i_ioctl_upload,
    input  logic [7:0]    i_ioctl_index,
    input  logic [24:0]   i_ioctl_addr,
    input  logic          i_ioctl_wr,
    input  logic          i_ioctl_rd,
    input  logic [7:0]    i_ioctl_dout,
    output logic [7:0]    o_ioctl_din,
    output logic          o_ioctl_wait,
    output logic [AW-1:0] o_ram_addr,
    output logic [7:0]    o_ram_di,
    output logic          o_ram_we,
    input  logic [7:0]    i_ram_q,
    output logic          o_dirty
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WPEND = 2'd1,
        S_RPEND = 2'd2,
        S_RCAP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;
    logic          r_oor;       // latched HPS address lies beyond the RAM
    logic          r_cpu_rd;    // previous cycle was a CPU read
    logic          r_upload_d;  // i_ioctl_upload delayed, for fall detection

    logic w_sel;
    logic w_oor;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_grant;
    logic w_dirty_set;
    logic w_dirty_clr;

    assign w_sel       = (i_ioctl_index == IDX);
    assign w_oor       = |i_ioctl_addr[24:AW];
    assign w_wr_acc    = w_sel & i_ioctl_download & i_ioctl_wr;
    assign w_rd_acc    = w_sel & i_ioctl_upload & i_ioctl_rd;
    assign w_grant     = ~i_cpu_cs;
    assign w_dirty_set = i_cpu_cs & i_cpu_we;
    assign w_dirty_clr = w_sel & r_upload_d & ~i_ioctl_upload;

    // Port mux. The CPU path is combinational so its writes land in the same
    // cycle; the HPS path uses the latched address/data. Nothing is written
    // while reset is asserted, so an in-flight HPS write is dropped cleanly.
    always_comb begin
        o_ram_addr = r_addr;
        o_ram_di   = r_data;
        o_ram_we   = 1'b0;
        if (i_cpu_cs) begin
            o_ram_addr = i_cpu_addr;
            o_ram_di   = i_cpu_din;
            o_ram_we   = i_cpu_we & ~i_reset;
        end else if (r_state == S_WPEND) begin
            o_ram_we   = ~r_oor & ~i_reset;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_oor        <= 1'b0;
            r_cpu_rd     <= 1'b0;
            r_upload_d   <= 1'b0;
            o_cpu_dout   <= '0;
            o_ioctl_din  <= '0;
            o_ioctl_wait <= 1'b0;
            o_dirty      <= 1'b0;
        end else begin
            r_cpu_rd   <= i_cpu_cs & ~i_cpu_we;
            r_upload_d <= i_ioctl_upload;

            if (r_cpu_rd) begin
                o_cpu_dout <= i_ram_q;
            end

            // A CPU write in the same cycle as the upload fall keeps dirty set,
            // so that write is not lost from the next save.
            if (w_dirty_set) begin
                o_dirty <= 1'b1;
            end else if (w_dirty_clr) begin
                o_dirty <= 1'b0;
            end

            // Strobes outside IDLE are protocol violations and simply ignored.
            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc) begin
                        r_state      <= S_WPEND;
                        r_addr       <= i_ioctl_addr[AW-1:0];
                        r_data       <= i_ioctl_dout;
                        r_oor        <= w_oor;
                        o_ioctl_wait <= 1'b1;
                    end else if (w_rd_acc) begin
                        r_state      <= S_RPEND;
                        r_addr       <= i_ioctl_addr[AW-1:0];
                        r_oor        <= w_oor;
                        o_ioctl_wait <= 1'b1;
                    end
                end
                S_WPEND: begin
                    if (w_grant) begin
                        r_state      <= S_IDLE;
                        o_ioctl_wait <= 1'b0;
                    end
                end
                S_RPEND: begin
                    if (w_grant) begin
                        r_state <= S_RCAP;
                    end
                end
                S_RCAP: begin
                    // ram_q reflects the address driven in the grant cycle;
                    // a CPU access now only affects next cycle's ram_q.
                    o_ioctl_din  <= r_oor ? 8'hFF : i_ram_q;
                    o_ioctl_wait <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_williams_nvram_arb.sv
// ---------------------------------------------------------------------------
// tb_williams_nvram_arb
//
// A driver applies one stimulus vector per cycle. It updates a transaction
// level model of the NVRAM contents and of the HPS access in flight. It pushes
// the expected responses into scoreboard queues, tagged with the cycle in
// which they are due. A monitor on the falling edge retires due expectations
// and compares them with the DUT outputs and the RAM port activity.
// ---------------------------------------------------------------------------
module tb_williams_nvram_arb;
    localparam int         AW  = 10;
    localparam logic [7:0] IDX = 8'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cpu_cs, cpu_we, ioctl_download, ioctl_upload;
    logic          ioctl_wr, ioctl_rd, ioctl_wait, ram_we, dirty;
    logic [AW-1:0] cpu_addr, ram_addr;
    logic [7:0]    cpu_din, cpu_dout, ioctl_index, ioctl_dout, ioctl_din, ram_di, ram_q;
    logic [24:0]   ioctl_addr;

    williams_nvram_arb #(.AW(AW), .IDX(IDX)) dut (
        .i_clk_sys(clk), .i_reset(reset), .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we),
        .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din), .o_cpu_dout(cpu_dout),
        .i_ioctl_download(ioctl_download), .i_ioctl_upload(ioctl_upload),
        .i_ioctl_index(ioctl_index), .i_ioctl_addr(ioctl_addr), .i_ioctl_wr(ioctl_wr),
        .i_ioctl_rd(ioctl_rd), .i_ioctl_dout(ioctl_dout), .o_ioctl_din(ioctl_din),
        .o_ioctl_wait(ioctl_wait), .o_ram_addr(ram_addr), .o_ram_di(ram_di),
        .o_ram_we(ram_we), .i_ram_q(ram_q), .o_dirty(dirty)
    );

    // The NVRAM itself: a synchronous RAM with one cycle of read latency.
    logic [7:0] mem [0:1023] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_di;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic        rst, cs, we;
        logic [9:0]  ca;
        logic [7:0]  cd;
        logic        dl, ul;
        logic [7:0]  idx;
        logic [24:0] ia;
        logic        wr, rd;
        logic [7:0]  id;
    } stim_t;

    typedef struct { int due; int kind; logic [7:0] val; } exp_t;
    typedef struct { int due; logic [9:0] a; logic [7:0] d; } wr_t;
    localparam int K_WAIT = 0, K_DIRTY = 1, K_CDOUT = 2, K_DIN = 3;
    // What the pending HPS request is waiting for.
    localparam int P_NONE = 0, P_WR = 1, P_RD = 2, P_CAP = 3;

    exp_t eq[$];
    wr_t  cpu_wq[$], hps_wq[$];

    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};
    int         m_pend = P_NONE;
    logic [9:0] m_addr;
    logic [7:0] m_data, m_cap;
    logic       m_oor, m_wait, m_dirty, m_ul_prev;

    int  n_tests = 0, n_fail = 0;
    bit  chk_en = 1'b0;
    int  zero_cyc = -1;

    task automatic push(input int due, input int kind, input logic [7:0] val);
        exp_t e;
        e.due = due; e.kind = kind; e.val = val;
        eq.push_back(e);
    endtask

    task automatic step(input stim_t s);
        int   c;
        logic sel;
        logic nwait, ndirty;
        wr_t  w;
        c = cyc;
        reset = s.rst; cpu_cs = s.cs; cpu_we = s.we; cpu_addr = s.ca; cpu_din = s.cd;
        ioctl_download = s.dl; ioctl_upload = s.ul; ioctl_index = s.idx;
        ioctl_addr = s.ia; ioctl_wr = s.wr; ioctl_rd = s.rd; ioctl_dout = s.id;
        sel = (s.idx == IDX);
        if (s.rst) begin
            // Everything in flight is discarded; all registered outputs clear.
            m_pend = P_NONE; m_wait = 1'b0; m_dirty = 1'b0; m_ul_prev = s.ul;
            push(c + 1, K_WAIT, 8'd0); push(c + 1, K_DIRTY, 8'd0);
            push(c + 1, K_CDOUT, 8'd0); push(c + 1, K_DIN, 8'd0);
        end else begin
            nwait = m_wait; ndirty = m_dirty;
            if (s.cs && s.we) begin
                w.due = c; w.a = s.ca; w.d = s.cd; cpu_wq.push_back(w);
                ref_mem[s.ca] = s.cd;
            end
            if (s.cs && !s.we) push(c + 2, K_CDOUT, ref_mem[s.ca]);
            if (m_pend == P_NONE) begin
                if (sel && s.dl && s.wr) begin
                    m_pend = P_WR; m_addr = s.ia[9:0]; m_data = s.id;
                    m_oor = (s.ia >= 25'd1024); nwait = 1'b1;
                end else if (sel && s.ul && s.rd) begin
                    m_pend = P_RD; m_addr = s.ia[9:0];
                    m_oor = (s.ia >= 25'd1024); nwait = 1'b1;
                end
            end else if (m_pend == P_WR) begin
                if (!s.cs) begin
                    if (!m_oor) begin
                        w.due = c; w.a = m_addr; w.d = m_data; hps_wq.push_back(w);
                        ref_mem[m_addr] = m_data;
                    end
                    m_pend = P_NONE; nwait = 1'b0;
                end
            end else if (m_pend == P_RD) begin
                if (!s.cs) begin
                    m_cap = m_oor ? 8'hFF : ref_mem[m_addr];
                    m_pend = P_CAP;
                end
            end else begin
                push(c + 1, K_DIN, m_cap);
                m_pend = P_NONE; nwait = 1'b0;
            end
            if (s.cs && s.we) ndirty = 1'b1;
            else if (sel && m_ul_prev && !s.ul) ndirty = 1'b0;
            m_ul_prev = s.ul;
            m_wait = nwait; m_dirty = ndirty;
            push(c + 1, K_WAIT, {7'd0, nwait});
            push(c + 1, K_DIRTY, {7'd0, ndirty});
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic       e_wait = 1'b0, e_dirty = 1'b0;
    logic [7:0] e_cdout = 8'd0, e_din = 8'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic lost(input string nm, input wr_t w);
        n_tests++;
        n_fail++;
        $display("FAIL %s @cyc %0d: write %0h<=%0h due %0d never seen", nm, cyc, w.a, w.d, w.due);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < eq.size();) begin
                if (eq[i].due <= cyc) begin
                    case (eq[i].kind)
                        K_WAIT:  e_wait  = eq[i].val[0];
                        K_DIRTY: e_dirty = eq[i].val[0];
                        K_CDOUT: e_cdout = eq[i].val;
                        default: e_din   = eq[i].val;
                    endcase
                    eq.delete(i);
                end else begin
                    i++;
                end
            end
            check("ioctl_wait", 32'(ioctl_wait), 32'(e_wait));
            check("dirty", 32'(dirty), 32'(e_dirty));
            check("cpu_dout", 32'(cpu_dout), 32'(e_cdout));
            check("ioctl_din", 32'(ioctl_din), 32'(e_din));

            if (ram_we === 1'b1) begin
                if (cpu_cs === 1'b1) begin
                    if (cpu_wq.size() == 0) check("cpu_wr_spurious", 32'(ram_addr), 32'hFFFF_FFFF);
                    else begin
                        wr_t w;
                        w = cpu_wq.pop_front();
                        check("cpu_wr_addr", 32'(ram_addr), 32'(w.a));
                        check("cpu_wr_data", 32'(ram_di), 32'(w.d));
                        check("cpu_wr_cyc", 32'(cyc), 32'(w.due));
                    end
                end else begin
                    if (hps_wq.size() == 0) check("hps_wr_spurious", 32'(ram_addr), 32'hFFFF_FFFF);
                    else begin
                        wr_t w;
                        w = hps_wq.pop_front();
                        check("hps_wr_addr", 32'(ram_addr), 32'(w.a));
                        check("hps_wr_data", 32'(ram_di), 32'(w.d));
                        check("hps_wr_cyc", 32'(cyc), 32'(w.due));
                    end
                end
            end else begin
                check("ram_we_known", 32'(ram_we), 32'd0);
            end
            while (cpu_wq.size() > 0 && cpu_wq[0].due < cyc) lost("cpu_wr_missing", cpu_wq.pop_front());
            while (hps_wq.size() > 0 && hps_wq[0].due < cyc) lost("hps_wr_missing", hps_wq.pop_front());

            if (cyc == zero_cyc) begin
                check("rst_ram_addr", 32'(ram_addr), 32'd0);
                check("rst_ram_di", 32'(ram_di), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic stim_t idle_s(input logic dl, input logic ul, input logic [7:0] idx);
        stim_t s;
        s = '0; s.dl = dl; s.ul = ul; s.idx = idx;
        return s;
    endfunction

    task automatic idle(input int n, input logic dl, input logic ul, input logic [7:0] idx);
        for (int k = 0; k < n; k++) step(idle_s(dl, ul, idx));
    endtask

    task automatic cpu_op(input logic we, input logic [9:0] a, input logic [7:0] d,
                          input logic ul, input logic [7:0] idx);
        stim_t s;
        s = idle_s(1'b0, ul, idx); s.cs = 1'b1; s.we = we; s.ca = a; s.cd = d;
        step(s);
    endtask

    task automatic hps_op(input logic wr, input logic [24:0] a, input logic [7:0] d,
                          input logic [7:0] idx);
        stim_t s;
        s = idle_s(wr, !wr, idx); s.wr = wr; s.rd = !wr; s.ia = a; s.id = d;
        step(s);
    endtask

    initial begin
        stim_t s;
        step(idle_s(1'b0, 1'b0, 8'd0));
        s = idle_s(1'b0, 1'b0, 8'd0); s.rst = 1'b1;
        step(s);
        chk_en = 1'b1;
        idle(2, 1'b0, 1'b0, IDX);

        // Download to a free port: one-cycle write, one-cycle wait.
        hps_op(1'b1, 25'd3, 8'h5A, IDX);
        idle(3, 1'b1, 1'b0, IDX);

        // Contention: the CPU holds the port for four cycles, and its writes
        // land first (one of them to the same address as the HPS write).
        hps_op(1'b1, 25'd20, 8'h33, IDX);
        for (int k = 0; k < 4; k++) begin
            s = idle_s(1'b1, 1'b0, IDX); s.cs = 1'b1; s.we = 1'b1;
            s.ca = 10'(20 + k); s.cd = 8'(8'h90 + k);
            step(s);
        end
        idle(3, 1'b1, 1'b0, IDX);
        cpu_op(1'b0, 10'd20, 8'h00, 1'b0, IDX);
        idle(3, 1'b0, 1'b0, IDX);

        // Upload: in range returns the RAM data, out of range returns FF.
        cpu_op(1'b1, 10'd7, 8'hC3, 1'b0, IDX);
        idle(1, 1'b0, 1'b1, IDX);
        hps_op(1'b0, 25'd7, 8'h00, IDX);
        idle(4, 1'b0, 1'b1, IDX);
        hps_op(1'b0, 25'd1024, 8'h00, IDX);
        idle(4, 1'b0, 1'b1, IDX);
        hps_op(1'b1, 25'd1030, 8'hEE, IDX);   // out-of-range write is dropped
        idle(3, 1'b0, 1'b0, IDX);             // upload falls -> dirty clears

        // Dirty: a set in the same cycle as the upload fall wins.
        cpu_op(1'b1, 10'd100, 8'h11, 1'b0, IDX);
        idle(2, 1'b0, 1'b1, IDX);
        cpu_op(1'b1, 10'd101, 8'h22, 1'b0, IDX);
        idle(2, 1'b0, 1'b1, IDX);
        idle(2, 1'b0, 1'b0, IDX);

        // Index filter: a foreign index never touches the RAM.
        hps_op(1'b1, 25'd5, 8'hAB, 8'd0);
        idle(3, 1'b1, 1'b0, 8'd0);

        // Reset while a read is pending, then a normal read.
        hps_op(1'b0, 25'd9, 8'h00, IDX);
        zero_cyc = cyc + 1;
        s = idle_s(1'b0, 1'b1, IDX); s.rst = 1'b1;
        step(s);
        idle(1, 1'b0, 1'b1, IDX);
        hps_op(1'b0, 25'd7, 8'h00, IDX);
        idle(4, 1'b0, 1'b1, IDX);
        idle(2, 1'b0, 1'b0, IDX);

        // Randomized sessions with CPU traffic, stray strobes and resets.
        for (int seg = 0; seg < 40; seg++) begin
            logic       up;
            logic [7:0] idx;
            up  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 7) == 0) ? 8'd0 : IDX;
            for (int k = 0; k < 50; k++) begin
                s = idle_s(!up, up, idx);
                s.cs = ($urandom_range(0, 2) != 0);
                s.we = 1'($urandom_range(0, 1));
                s.ca = 10'($urandom);
                s.cd = 8'($urandom);
                s.id = 8'($urandom);
                s.ia = ($urandom_range(0, 9) == 0) ? 25'(1024 + $urandom_range(0, 5000))
                                                  : 25'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) == 0) begin
                    s.wr = !up; s.rd = up;
                end
                if (k < 45 && $urandom_range(0, 299) == 0) begin
                    s.rst = 1'b1; s.cs = 1'b0;
                end
                step(s);
            end
            idle(4, 1'b0, 1'b0, idx);
        end
        idle(3, 1'b0, 1'b0, IDX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
